// File: rtl/core_bus_arbiter.sv
// core_bus_arbiter: merges NCH pulse-protocol core bus channels onto one
// downstream memory port. One-entry buffer per channel, round-robin grant,
// a single outstanding downstream transaction, response routed to the owner.

// Per-channel request buffer: latches a request pulse unless the channel
// already has one queued or in flight, in which case it flags an overrun.
module core_bus_arbiter_chbuf #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_req,
  input  logic                i_mode,
  input  logic [ADDR_W-1:0]   i_addr,
  input  logic [DATA_W-1:0]   i_wdata,
  input  logic [DATA_W/8-1:0] i_wstrb,
  input  logic                i_owned,
  input  logic                i_clr,
  output logic                o_pend,
  output logic                o_ovr,
  output logic                o_mode,
  output logic [ADDR_W-1:0]   o_addr,
  output logic [DATA_W-1:0]   o_wdata,
  output logic [DATA_W/8-1:0] o_wstrb
);
  logic w_take;

  // Accept only when the slot is free and this channel is not in flight.
  assign w_take = i_req && !o_pend && !i_owned;

  // Buffer, pending and sticky overrun registers. A grant only clears a set
  // pending bit, and a pulse on a pending channel never loads, so the two
  // updates cannot collide.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_pend  <= 1'b0;
      o_ovr   <= 1'b0;
      o_mode  <= 1'b0;
      o_addr  <= '0;
      o_wdata <= '0;
      o_wstrb <= '0;
    end else begin
      o_pend <= (o_pend && !i_clr) || w_take;
      if (i_req && !w_take) o_ovr <= 1'b1;
      if (w_take) begin
        o_mode  <= i_mode;
        o_addr  <= i_addr;
        o_wdata <= i_wdata;
        o_wstrb <= i_wstrb;
      end
    end
  end
endmodule

module core_bus_arbiter #(
  parameter int NCH    = 2,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NCH-1:0]          ch_request_enable,
  input  logic [NCH-1:0]          ch_mode,
  input  logic [NCH*ADDR_W-1:0]   ch_addr,
  input  logic [NCH*DATA_W-1:0]   ch_wdata,
  input  logic [NCH*DATA_W/8-1:0] ch_wstrb,
  output logic [NCH-1:0]          ch_response_enable,
  output logic [DATA_W-1:0]       ch_resp_data,
  output logic [NCH-1:0]          ch_overrun,
  output logic                    mem_request_enable,
  output logic                    mreq_mode,
  output logic [ADDR_W-1:0]       mreq_addr,
  output logic [DATA_W-1:0]       mreq_wdata,
  output logic [DATA_W/8-1:0]     mreq_wstrb,
  input  logic                    mem_response_enable,
  input  logic [DATA_W-1:0]       mresp_data,
  output logic                    busy
);
  localparam int SW = DATA_W/8;
  localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

  state_t                     r_state, w_next;
  logic [IW-1:0]              r_gnt, r_rr, w_pick;
  logic                       w_found;
  logic [NCH-1:0]             w_pend, w_owned, w_clr, w_bmode;
  logic [NCH-1:0][ADDR_W-1:0] w_baddr;
  logic [NCH-1:0][DATA_W-1:0] w_bwdata;
  logic [NCH-1:0][SW-1:0]     w_bwstrb;

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    // The granted channel stays "owned" through ISSUE and WAIT so a fresh
    // pulse cannot overtake its own outstanding transaction.
    assign w_owned[g] = (r_state != S_IDLE) && (r_gnt == IW'(g));
    assign w_clr[g]   = (r_state == S_IDLE) && w_found && (w_pick == IW'(g));

    core_bus_arbiter_chbuf #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_buf (
      .clk     (clk),
      .rst     (rst),
      .i_req   (ch_request_enable[g]),
      .i_mode  (ch_mode[g]),
      .i_addr  (ch_addr[g*ADDR_W +: ADDR_W]),
      .i_wdata (ch_wdata[g*DATA_W +: DATA_W]),
      .i_wstrb (ch_wstrb[g*SW +: SW]),
      .i_owned (w_owned[g]),
      .i_clr   (w_clr[g]),
      .o_pend  (w_pend[g]),
      .o_ovr   (ch_overrun[g]),
      .o_mode  (w_bmode[g]),
      .o_addr  (w_baddr[g]),
      .o_wdata (w_bwdata[g]),
      .o_wstrb (w_bwstrb[g])
    );
  end

  // Round-robin pick: first pending channel at or after r_rr, modulo NCH.
  // Scanning downward lets the nearest candidate overwrite farther ones.
  always_comb begin
    int idx;
    w_found = 1'b0;
    w_pick  = '0;
    idx     = 0;
    for (int k = NCH-1; k >= 0; k--) begin
      idx = (int'(r_rr) + k) % NCH;
      if (w_pend[idx]) begin
        w_found = 1'b1;
        w_pick  = IW'(idx);
      end
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic; a response outside WAIT is ignored.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_found) w_next = S_ISSUE;
      S_ISSUE: w_next = S_WAIT;
      S_WAIT:  if (mem_response_enable) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Grant capture, rr advance and response routing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_gnt              <= '0;
      r_rr               <= '0;
      mreq_mode          <= 1'b0;
      mreq_addr          <= '0;
      mreq_wdata         <= '0;
      mreq_wstrb         <= '0;
      ch_resp_data       <= '0;
      ch_response_enable <= '0;
    end else begin
      ch_response_enable <= '0;
      if (r_state == S_IDLE && w_found) begin
        r_gnt      <= w_pick;
        mreq_mode  <= w_bmode[w_pick];
        mreq_addr  <= w_baddr[w_pick];
        mreq_wdata <= w_bwdata[w_pick];
        mreq_wstrb <= w_bwstrb[w_pick];
      end
      if (r_state == S_ISSUE)
        r_rr <= (r_gnt == IW'(NCH-1)) ? '0 : r_gnt + 1'b1;
      if (r_state == S_WAIT && mem_response_enable) begin
        ch_resp_data       <= mresp_data;
        ch_response_enable <= NCH'(1) << r_gnt;
      end
    end
  end

  assign mem_request_enable = (r_state == S_ISSUE);
  assign busy               = (r_state != S_IDLE);
endmodule

// File: doc/core_bus_arbiter.md
Name: core_bus_arbiter

Overview:
- Parametrised successor to the core-level bus wrapper.
- Merges NCH independent core bus channels (fetch, mem, plus future channels such as a page-table walker) onto one downstream memory port.
- Every port uses the core's pulse-style request_enable/response_enable protocol.
- Each channel gets a one-entry request buffer, round-robin arbitration, one outstanding downstream transaction, and response routing back to the originating channel.

Parameters:
- NCH, 2, number of upstream channels (≥2); channel 0 = fetch, 1 = mem by convention.
- ADDR_W, 32, address width.
- DATA_W, 32, data width; the wstrb width is DATA_W/8.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- ch_request_enable  in  NCH  per-channel one-cycle request pulse.
- ch_mode  in  NCH  per-channel mode: 1 = write, 0 = read.
- ch_addr  in  NCH*ADDR_W  per-channel address; channel i occupies slice [i*ADDR_W +: ADDR_W].
- ch_wdata  in  NCH*DATA_W  per-channel write data.
- ch_wstrb  in  NCH*DATA_W/8  per-channel byte strobes.
- ch_response_enable  out  NCH  per-channel one-cycle response pulse.
- ch_resp_data  out  DATA_W  response data, shared by all channels; valid when any ch_response_enable bit is high.
- ch_overrun  out  NCH  sticky flag: a request was dropped on that channel.
- mem_request_enable  out  1  downstream one-cycle request pulse.
- mreq_mode, mreq_addr, mreq_wdata, mreq_wstrb  out  1/ADDR_W/DATA_W/DATA_W/8  downstream request fields.
- mem_response_enable  in  1  downstream one-cycle response pulse.
- mresp_data  in  DATA_W  downstream response data.
- busy  out  1  high while in ISSUE or WAIT.

Behaviour:
- Reset values: all outputs 0, all pending bits 0, rr pointer 0, state IDLE. Reset asserted mid-transaction aborts it; a late mem_response_enable arriving after reset, while IDLE, is ignored.
- Capture:
  - A ch_request_enable[i] pulse sampled at a clock edge latches mode/addr/wdata/wstrb into buffer i and sets pending[i].
  - If pending[i] is already set, or channel i is granted and awaiting a response, the new pulse is dropped, buffer i is unchanged, and ch_overrun[i] is set. ch_overrun clears only on reset.
- State machine (IDLE -> ISSUE -> WAIT -> IDLE):
  - IDLE: if any pending bit is set, grant the first pending channel searching from rr upward modulo NCH. Register the grant index, drive the mreq_* fields from buffer[grant], clear pending[grant], go to ISSUE. Pending bits are evaluated after the same-edge capture, so a request sampled at edge k can be granted at edge k+1.
  - ISSUE: mem_request_enable = 1 for exactly this one cycle; mreq_* fields stay stable from ISSUE through WAIT. Next state WAIT; rr = grant+1 mod NCH.
  - WAIT: hold until mem_response_enable. On that edge, register ch_resp_data = mresp_data and set ch_response_enable[grant] = 1 for exactly one cycle. Next state IDLE.
- Latency: minimum 2 cycles from the channel pulse to mem_request_enable; 1 cycle from mem_response_enable to ch_response_enable.
- Back-to-back: the earliest re-issue is the edge after the response returns to IDLE, giving a minimum 3-cycle gap between mem_request_enable pulses.
- Downstream contract: mem_response_enable never arrives in ISSUE. If it arrives in IDLE or ISSUE it is ignored.
- Simultaneous events:
  - A new request on channel j while channel i's response returns is captured normally.
  - A new request on the channel currently in WAIT is an overrun; this prevents reordering.
- Round-robin guarantee: with all NCH channels continuously pending, every channel is granted once per NCH grants.

Test Plan:
- Single read: ch0 pulse, addr=0x1000, mode=0 → mem_request_enable 2 cycles later with mreq_addr=0x1000; mem_response_enable with mresp_data=0xDEADBEEF → ch_response_enable=0b01, ch_resp_data=0xDEADBEEF 1 cycle later.
- Simultaneous: ch0 and ch1 pulse on the same edge (rr=0) → ch0 granted first; after its response, ch1 granted; rr ends at 0.
- Fairness (NCH=3): all channels kept pending for 6 grants → grant order 0,1,2,0,1,2.
- Overrun: second ch1 pulse while ch1 is pending → ch_overrun=0b10, buffer still holds the first address; only one downstream request is issued.
- Write path: ch1 mode=1, wdata=0x12345678, wstrb=0xF → identical values on mreq_wdata/mreq_wstrb/mreq_mode during ISSUE and WAIT.
- Reset in WAIT: assert rst, then deliver mem_response_enable → no ch_response_enable, busy=0, all pending=0.
